// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit: FSM state codes and
// operand-forwarding select values.
package pipeline_hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // A stage can supply rs only if it really writes a non-x0 register equal to rs.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic rf_en, input logic uses);
        return uses && rf_en && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Three-stage priority comparator (EX > MEM > WB) producing one operand's
// forwarding select, plus the raw EX match used for load-use detection.
module pipeline_hazard_unit_fwd_select
    import pipeline_hazard_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       uses,
    input  logic [4:0] ex_rd,
    input  logic       ex_en,
    input  logic [4:0] mem_rd,
    input  logic       mem_en,
    input  logic       mem_block,
    input  logic [4:0] wb_rd,
    input  logic       wb_en,
    output logic [1:0] sel,
    output logic       ex_hit
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        ex_hit  = src_match(ex_rd, rs, ex_en, uses);
        // A blocked MEM source (load data not yet available) drops through to WB.
        mem_hit = src_match(mem_rd, rs, mem_en, uses) && !mem_block;
        wb_hit  = src_match(wb_rd, rs, wb_en, uses);
        sel     = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall sequencing,
// taken-branch flush sequencing and saturating stall/flush event counters.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_Uses_rs1,
    input  logic             ID_Uses_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_RF_Enable,
    input  logic             EX_Load_Instr,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_RF_Enable,
    input  logic [4:0]       WB_rd,
    input  logic             WB_RF_Enable,
    input  logic             EX_Branch_Taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [1:0]       FWD_A_sel,
    output logic [1:0]       FWD_B_sel,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       stall_left_q, stall_left_d;
    logic             mem_load_q, mem_load_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0] sel_a, sel_b;
    logic       ex_hit_a, ex_hit_b;
    logic       mem_block;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;

    // With a two-cycle load stall the load's data is only usable from WB.
    assign mem_block = (LOAD_STALL_CYCLES == 2) && mem_load_q;

    pipeline_hazard_unit_fwd_select u_fwd_a (
        .rs        (ID_rs1),
        .uses      (ID_Uses_rs1),
        .ex_rd     (EX_rd),
        .ex_en     (EX_RF_Enable),
        .mem_rd    (MEM_rd),
        .mem_en    (MEM_RF_Enable),
        .mem_block (mem_block),
        .wb_rd     (WB_rd),
        .wb_en     (WB_RF_Enable),
        .sel       (sel_a),
        .ex_hit    (ex_hit_a)
    );

    pipeline_hazard_unit_fwd_select u_fwd_b (
        .rs        (ID_rs2),
        .uses      (ID_Uses_rs2),
        .ex_rd     (EX_rd),
        .ex_en     (EX_RF_Enable),
        .mem_rd    (MEM_rd),
        .mem_en    (MEM_RF_Enable),
        .mem_block (mem_block),
        .wb_rd     (WB_rd),
        .wb_en     (WB_RF_Enable),
        .sel       (sel_b),
        .ex_hit    (ex_hit_b)
    );

    assign load_use  = EX_Load_Instr && (ex_hit_a || ex_hit_b);
    assign stall_evt = !Reset && ((state_q == ST_STALL) ||
                                  (state_q == ST_RUN && !EX_Branch_Taken && load_use));
    assign flush_evt = !Reset && (state_q == ST_RUN) && EX_Branch_Taken;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_RUN;
            stall_left_q <= 2'd0;
            mem_load_q   <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            mem_load_q   <= mem_load_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        mem_load_d   = EX_Load_Instr;
        case (state_q)
            ST_RUN: begin
                if (EX_Branch_Taken) begin
                    state_d = ST_FLUSH;
                end else if (load_use && (LOAD_STALL_CYCLES == 2)) begin
                    state_d      = ST_STALL;
                    stall_left_d = STALL_RELOAD;
                end
            end
            ST_STALL: begin
                stall_left_d = stall_left_q - 2'd1;
                if (stall_left_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        PC_LE        = 1'b1;
        IF_ID_LE     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        FWD_A_sel    = sel_a;
        FWD_B_sel    = sel_b;
        if (Reset) begin
            PC_LE        = 1'b0;
            IF_ID_LE     = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            FWD_A_sel    = FWD_RF;
            FWD_B_sel    = FWD_RF;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // IF/ID must not load while its flush is applied.
                    if (EX_Branch_Taken) begin
                        IF_ID_LE     = 1'b0;
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (load_use) begin
                        PC_LE        = 1'b0;
                        IF_ID_LE     = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end
                end
                ST_STALL: begin
                    PC_LE        = 1'b0;
                    IF_ID_LE     = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: three instances (1-cycle, 2-cycle and a
// narrow-counter variant) share stimulus and are checked against a reference model.
module tb_pipeline_hazard_unit;
    import pipeline_hazard_unit_pkg::*;

    logic       clk;
    logic       Reset;
    logic [4:0] ID_rs1, ID_rs2, EX_rd, MEM_rd, WB_rd;
    logic       ID_Uses_rs1, ID_Uses_rs2, EX_RF_Enable, EX_Load_Instr;
    logic       MEM_RF_Enable, WB_RF_Enable, EX_Branch_Taken;

    logic        pc_le[3], ifid_le[3], ifid_fl[3], bubble[3];
    logic [1:0]  fwd_a[3], fwd_b[3], st[3];
    logic [15:0] scnt[3], fcnt[3];
    logic [1:0]  scnt_n, fcnt_n;

    int vectors    = 0;
    int miscompares = 0;

    int lsc[3] = '{1, 2, 1};
    int cmax[3] = '{65535, 65535, 3};
    int stall_left[3], stalls[3], flushes[3];
    bit mask[3], mem_ld[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) d0 (
        .clk(clk), .Reset(Reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_Uses_rs1(ID_Uses_rs1), .ID_Uses_rs2(ID_Uses_rs2),
        .EX_rd(EX_rd), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
        .MEM_rd(MEM_rd), .MEM_RF_Enable(MEM_RF_Enable), .WB_rd(WB_rd),
        .WB_RF_Enable(WB_RF_Enable), .EX_Branch_Taken(EX_Branch_Taken),
        .PC_LE(pc_le[0]), .IF_ID_LE(ifid_le[0]), .IF_ID_Flush(ifid_fl[0]),
        .ID_EX_Bubble(bubble[0]), .FWD_A_sel(fwd_a[0]), .FWD_B_sel(fwd_b[0]),
        .Stall_Count(scnt[0]), .Flush_Count(fcnt[0]), .dbg_state(st[0])
    );

    pipeline_hazard_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(16)) d1 (
        .clk(clk), .Reset(Reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_Uses_rs1(ID_Uses_rs1), .ID_Uses_rs2(ID_Uses_rs2),
        .EX_rd(EX_rd), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
        .MEM_rd(MEM_rd), .MEM_RF_Enable(MEM_RF_Enable), .WB_rd(WB_rd),
        .WB_RF_Enable(WB_RF_Enable), .EX_Branch_Taken(EX_Branch_Taken),
        .PC_LE(pc_le[1]), .IF_ID_LE(ifid_le[1]), .IF_ID_Flush(ifid_fl[1]),
        .ID_EX_Bubble(bubble[1]), .FWD_A_sel(fwd_a[1]), .FWD_B_sel(fwd_b[1]),
        .Stall_Count(scnt[1]), .Flush_Count(fcnt[1]), .dbg_state(st[1])
    );

    pipeline_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) d2 (
        .clk(clk), .Reset(Reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_Uses_rs1(ID_Uses_rs1), .ID_Uses_rs2(ID_Uses_rs2),
        .EX_rd(EX_rd), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
        .MEM_rd(MEM_rd), .MEM_RF_Enable(MEM_RF_Enable), .WB_rd(WB_rd),
        .WB_RF_Enable(WB_RF_Enable), .EX_Branch_Taken(EX_Branch_Taken),
        .PC_LE(pc_le[2]), .IF_ID_LE(ifid_le[2]), .IF_ID_Flush(ifid_fl[2]),
        .ID_EX_Bubble(bubble[2]), .FWD_A_sel(fwd_a[2]), .FWD_B_sel(fwd_b[2]),
        .Stall_Count(scnt_n), .Flush_Count(fcnt_n), .dbg_state(st[2])
    );

    assign scnt[2] = {14'd0, scnt_n};
    assign fcnt[2] = {14'd0, fcnt_n};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: which stage (in priority order) supplies this source.
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic uses, input int k);
        logic [4:0] rds[3];
        logic       ens[3];
        rds = '{EX_rd, MEM_rd, WB_rd};
        ens = '{EX_RF_Enable, MEM_RF_Enable && !(lsc[k] == 2 && mem_ld[k]), WB_RF_Enable};
        for (int s = 0; s < 3; s++) begin
            if (uses && ens[s] && rds[s] != 5'd0 && rds[s] == rs) return 2'(s + 1);
        end
        return 2'b00;
    endfunction

    function automatic bit ref_load_use();
        bit h1, h2;
        h1 = ID_Uses_rs1 && EX_RF_Enable && EX_rd != 5'd0 && EX_rd == ID_rs1;
        h2 = ID_Uses_rs2 && EX_RF_Enable && EX_rd != 5'd0 && EX_rd == ID_rs2;
        return EX_Load_Instr && (h1 || h2);
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Compare every instance against the model away from the active edge.
    task automatic settle();
        logic [3:0] ctrl;
        logic [1:0] est;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (Reset)                                    ctrl = 4'b0011;
            else if (stall_left[k] > 0)                   ctrl = 4'b0001;
            else if (EX_Branch_Taken && !mask[k])         ctrl = 4'b1011;
            else if (ref_load_use() && !mask[k])          ctrl = 4'b0001;
            else                                          ctrl = 4'b1100;
            est = (stall_left[k] > 0) ? ST_STALL : (mask[k] ? ST_FLUSH : ST_RUN);
            chk($sformatf("d%0d_ctrl", k), {12'd0, pc_le[k], ifid_le[k], ifid_fl[k], bubble[k]},
                {12'd0, ctrl});
            chk($sformatf("d%0d_fwd", k), {12'd0, fwd_a[k], fwd_b[k]},
                Reset ? 16'd0 : {12'd0, ref_fwd(ID_rs1, ID_Uses_rs1, k), ref_fwd(ID_rs2, ID_Uses_rs2, k)});
            chk($sformatf("d%0d_stall_cnt", k), scnt[k], 16'(sat(stalls[k], cmax[k])));
            chk($sformatf("d%0d_flush_cnt", k), fcnt[k], 16'(sat(flushes[k], cmax[k])));
            chk($sformatf("d%0d_state", k), {14'd0, st[k]}, {14'd0, est});
        end
    endtask

    task automatic tick();
        bit hz;
        hz = ref_load_use();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (Reset) begin
                stall_left[k] = 0; stalls[k] = 0; flushes[k] = 0; mask[k] = 0; mem_ld[k] = 0;
            end else begin
                if (stall_left[k] > 0) begin
                    stall_left[k]--; stalls[k]++; mask[k] = 0;
                end else if (EX_Branch_Taken && !mask[k]) begin
                    flushes[k]++; mask[k] = 1;
                end else if (hz && !mask[k]) begin
                    stalls[k]++; stall_left[k] = lsc[k] - 1; mask[k] = 0;
                end else begin
                    mask[k] = 0;
                end
                mem_ld[k] = EX_Load_Instr;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ID_rs1 = 0; ID_rs2 = 0; ID_Uses_rs1 = 0; ID_Uses_rs2 = 0;
        EX_rd = 0; EX_RF_Enable = 0; EX_Load_Instr = 0;
        MEM_rd = 0; MEM_RF_Enable = 0; WB_rd = 0; WB_RF_Enable = 0;
        EX_Branch_Taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        settle();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            stall_left[k] = 0; stalls[k] = 0; flushes[k] = 0; mask[k] = 0; mem_ld[k] = 0;
        end
        idle_inputs();
        Reset = 1'b1;
        tick();
        do_reset();

        // Step 1: ALU result in EX forwarded to both operands.
        EX_rd = 5; EX_RF_Enable = 1; ID_rs1 = 5; ID_rs2 = 5; ID_Uses_rs1 = 1; ID_Uses_rs2 = 1;
        settle();
        chk("t1_fwd", {14'd0, fwd_a[0]}, 16'(FWD_EX));
        chk("t1_pcle", {15'd0, pc_le[0]}, 16'd1);
        tick();

        // Steps 2/3: load-use on rs2, d0 stalls once, d1 twice.
        do_reset();
        EX_rd = 7; EX_RF_Enable = 1; EX_Load_Instr = 1; ID_rs2 = 7; ID_Uses_rs2 = 1; ID_rs1 = 1;
        settle();
        chk("t2_bubble", {15'd0, bubble[0]}, 16'd1);
        tick();
        EX_rd = 0; EX_RF_Enable = 0; EX_Load_Instr = 0; MEM_rd = 7; MEM_RF_Enable = 1;
        settle();
        chk("t2_fwd_mem", {14'd0, fwd_b[0]}, 16'(FWD_MEM));
        chk("t2_stall_cnt", scnt[0], 16'd1);
        chk("t3_stall2", {15'd0, bubble[1]}, 16'd1);
        tick();
        MEM_rd = 0; MEM_RF_Enable = 0; WB_rd = 7; WB_RF_Enable = 1;
        settle();
        chk("t3_fwd_wb", {14'd0, fwd_b[1]}, 16'(FWD_WB));
        chk("t3_stall_cnt", scnt[1], 16'd2);
        tick();

        // Step 4: branch beats a simultaneous load-use hazard.
        do_reset();
        EX_rd = 4; EX_RF_Enable = 1; EX_Load_Instr = 1; ID_rs1 = 4; ID_Uses_rs1 = 1;
        EX_Branch_Taken = 1;
        settle();
        chk("t4_ctrl", {12'd0, pc_le[1], ifid_le[1], ifid_fl[1], bubble[1]}, 16'b1011);
        tick();
        settle();
        chk("t4_flush_cnt", fcnt[1], 16'd1);
        chk("t4_no_stall", {15'd0, pc_le[1]}, 16'd1);
        tick();
        EX_Branch_Taken = 0;

        // Step 5: x0 never forwards; EX beats MEM.
        do_reset();
        EX_rd = 0; MEM_rd = 0; WB_rd = 0; EX_RF_Enable = 1; MEM_RF_Enable = 1; WB_RF_Enable = 1;
        EX_Load_Instr = 1; ID_rs1 = 0; ID_Uses_rs1 = 1;
        settle();
        chk("t5_x0_fwd", {14'd0, fwd_a[0]}, 16'(FWD_RF));
        chk("t5_x0_nostall", {15'd0, bubble[0]}, 16'd0);
        tick();
        EX_Load_Instr = 0; EX_rd = 3; MEM_rd = 3; ID_rs1 = 3;
        settle();
        chk("t5_ex_prio", {14'd0, fwd_a[0]}, 16'(FWD_EX));
        tick();

        // Step 6: reset in the second stall cycle of d1.
        do_reset();
        EX_rd = 9; EX_RF_Enable = 1; EX_Load_Instr = 1; ID_rs1 = 9; ID_Uses_rs1 = 1;
        settle();
        tick();
        idle_inputs();
        Reset = 1'b1;
        settle();
        chk("t6_forced", {12'd0, pc_le[1], ifid_le[1], ifid_fl[1], bubble[1]}, 16'b0011);
        tick();
        Reset = 1'b0;
        settle();
        chk("t6_state", {14'd0, st[1]}, 16'(ST_RUN));
        chk("t6_cnt", scnt[1], 16'd0);
        tick();

        // Saturation: held hazard drives the 2-bit counter past its limit.
        do_reset();
        EX_rd = 2; EX_RF_Enable = 1; EX_Load_Instr = 1; ID_rs2 = 2; ID_Uses_rs2 = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            tick();
        end
        settle();
        chk("sat_stall_cnt", scnt[2], 16'd3);
        chk("nosat_stall_cnt", scnt[0], 16'd5);
        tick();

        // Random traffic with small register numbers so matches are frequent.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            Reset           = ($urandom_range(0, 59) == 0);
            ID_rs1          = 5'($urandom_range(0, 3));
            ID_rs2          = 5'($urandom_range(0, 3));
            ID_Uses_rs1     = 1'($urandom_range(0, 1));
            ID_Uses_rs2     = 1'($urandom_range(0, 1));
            EX_rd           = 5'($urandom_range(0, 3));
            EX_RF_Enable    = 1'($urandom_range(0, 1));
            EX_Load_Instr   = ($urandom_range(0, 2) == 0);
            MEM_rd          = 5'($urandom_range(0, 3));
            MEM_RF_Enable   = 1'($urandom_range(0, 1));
            WB_rd           = 5'($urandom_range(0, 3));
            WB_RF_Enable    = 1'($urandom_range(0, 1));
            EX_Branch_Taken = ($urandom_range(0, 6) == 0);
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
